// File: rtl/line_memory.sv
// line_memory: fixed-latency 128-bit line store behind the cache; LINE_MEM_ERR_EN adds out-of-range error reporting
module line_memory #(
  parameter int DEPTH = 4096,
  parameter int LATENCY = 10
) (
  input  logic         clk,
  input  logic         r_n,
  input  logic         cache2mem_valid,
  input  logic         cache2mem_rw,
  input  logic [31:0]  cache2mem_addr,
  input  logic [127:0] cache2mem_data,
  output logic [127:0] mem2cache_data,
  output logic         mem2cache_ready,
  output logic         mem_busy
`ifdef LINE_MEM_ERR_EN
  ,
  output logic         mem2cache_err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic rw, oor, oor_in, accept, unused;
  logic [AW-1:0] idx;
  logic [127:0] wdata;
  logic [127:0] mem [DEPTH];
  assign accept = state == IDLE && cache2mem_valid;
  assign mem2cache_ready = state == DONE;
  assign mem_busy = state != IDLE;
`ifdef LINE_MEM_ERR_EN
  assign unused = ^cache2mem_addr[3:0];
  assign oor_in = {4'b0, cache2mem_addr[31:4]} >= 32'(DEPTH);
  assign mem2cache_err = state == DONE && oor;
`else
  assign unused = ^{cache2mem_addr[31:AW+4], cache2mem_addr[3:0]};
  assign oor_in = 1'b0;
`endif
  always_comb begin
    next = state == IDLE ? (cache2mem_valid ? BUSY : IDLE) :
           state == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!r_n) begin
      state <= IDLE;
      cnt <= '0;
      mem2cache_data <= '0;
    end else begin
      state <= next;
      if (accept)
        cnt <= CW'(LATENCY - 1);
      else if (state == BUSY && cnt != '0)
        cnt <= cnt - CW'(1);
      if (state == BUSY && cnt == '0 && !rw)
        mem2cache_data <= oor ? '0 : mem[idx];
    end
  end
  always_ff @(posedge clk) begin
    if (r_n && accept) begin
      rw <= cache2mem_rw;
      idx <= cache2mem_addr[AW+3:4];
      wdata <= cache2mem_data;
      oor <= oor_in;
    end
  end
  // Commit on the edge leaving DONE so an aborting reset can still cancel the write
  always_ff @(posedge clk) begin
    if (r_n && state == DONE && rw && !oor)
      mem[idx] <= wdata;
  end
endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: directed scoreboard bench for line_memory (LATENCY 10 main instance, LATENCY 1 back-to-back instance)
module tb_line_memory;
  localparam int LAT = 10;
  logic clk = 0, r_n = 0;
  logic valid = 0, rw = 0;
  logic [31:0] addr = 0;
  logic [127:0] wdata = 0;
  logic [127:0] rdata, rd1;
  logic ready, busy, v1 = 0, rdy1, busy1;
`ifdef LINE_MEM_ERR_EN
  logic err, err1;
`endif
  int checks = 0, failures = 0;
  logic [127:0] sb[$];
  logic [127:0] model [int];
  logic [127:0] last_rd = '0;
  logic [0:8] er = 9'b010010010;
  logic [0:8] eb = 9'b110110110;

  always #5 clk = ~clk;

  line_memory #(.DEPTH(4096), .LATENCY(LAT)) dut (
    .clk(clk), .r_n(r_n), .cache2mem_valid(valid), .cache2mem_rw(rw),
    .cache2mem_addr(addr), .cache2mem_data(wdata), .mem2cache_data(rdata),
    .mem2cache_ready(ready), .mem_busy(busy)
`ifdef LINE_MEM_ERR_EN
    , .mem2cache_err(err)
`endif
  );

  line_memory #(.DEPTH(16), .LATENCY(1)) u1 (
    .clk(clk), .r_n(r_n), .cache2mem_valid(v1), .cache2mem_rw(1'b0),
    .cache2mem_addr(32'h0), .cache2mem_data(128'h0), .mem2cache_data(rd1),
    .mem2cache_ready(rdy1), .mem_busy(busy1)
`ifdef LINE_MEM_ERR_EN
    , .mem2cache_err(err1)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic oor_of(input logic [31:0] a);
`ifdef LINE_MEM_ERR_EN
    return a[31:4] >= 28'd4096;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[15:4]);
  endfunction

  task automatic start(input logic w, input logic [31:0] a, input logic [127:0] d);
    @(negedge clk);
    chk("idle_ready", 128'(ready), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
    valid = 1;
    rw = w;
    addr = a;
    wdata = d;
  endtask

  task automatic complete(input bit tog);
    logic w, o;
    logic [31:0] a;
    logic [127:0] d, e;
    int n;
    @(posedge clk);
    w = rw;
    a = addr;
    d = wdata;
    o = oor_of(a);
    if (w) e = last_rd;
    else if (o) e = '0;
    else e = model[idx_of(a)];
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    valid = 0;
    chk("accept_busy", 128'(busy), 128'(1));
    while (!ready && n < 4 * LAT) begin
      if (tog) begin
        valid = 1'($urandom);
        rw = 1'($urandom);
        addr = $urandom;
        wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      n++;
    end
    valid = 0;
    chk("latency", 128'(n), 128'(LAT));
    chk("ready_busy", 128'(busy), 128'(1));
    e = sb.pop_front();
    chk(w ? "write_data_hold" : "read_data", rdata, e);
`ifdef LINE_MEM_ERR_EN
    chk("err", 128'(err), 128'(o));
`endif
    if (!w) last_rd = e;
    else if (!o) model[idx_of(a)] = d;
  endtask

  initial begin
    valid = 1;
    rw = 1;
    addr = 32'h80;
    wdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 128'(ready), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_data", rdata, 128'(0));
    end
    r_n = 1;
    complete(0);
    start(1, 32'h0000_0040, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_0001);
    complete(0);
    start(0, 32'h0000_004C, 128'h0);
    complete(0);
    start(0, 32'h0000_0080, 128'h0);
    complete(0);
    // A new request is taken only from IDLE, one cycle after each ready pulse
    @(negedge clk);
    v1 = 1;
    @(posedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("b2b_ready", 128'(rdy1), 128'(er[k]));
      chk("b2b_busy", 128'(busy1), 128'(eb[k]));
      if (k == 6) v1 = 0;
    end
    start(1, 32'h0000_0040, 128'hABAB_ABAB_ABAB_ABAB_ABAB_ABAB_ABAB_ABAB);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      valid = 0;
      chk("abort_busy", 128'(busy), 128'(1));
      chk("abort_ready", 128'(ready), 128'(0));
    end
    r_n = 0;
    last_rd = '0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_rst_ready", 128'(ready), 128'(0));
      chk("abort_rst_busy", 128'(busy), 128'(0));
      chk("abort_rst_data", rdata, 128'(0));
    end
    r_n = 1;
    start(0, 32'h0000_0040, 128'h0);
    complete(0);
    start(1, 32'h0001_0040, 128'h5A5A_0000_FFFF_1234_0000_9999_AAAA_0042);
    complete(0);
    start(0, 32'h0000_0040, 128'h0);
    complete(0);
    start(0, 32'h0001_0040, 128'h0);
    complete(0);
    start(1, 32'h0000_0100, 128'hC0FF_EE00_1357_9BDF_2468_ACE0_F00D_0100);
    complete(1);
    start(0, 32'h0000_0100, 128'h0);
    complete(1);
    start(0, 32'h0000_0040, 128'h0);
    complete(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
